// File: rtl/gmii_tx_pkg.sv
// Shared definitions for the GMII transmit path: scheduler states, packet-type codes
// and timing defaults used by both the scheduler and the tx engine.
package gmii_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    FRAME = 2'd2,
    GAP   = 2'd3
  } sched_state_e;

  localparam logic [7:0]  PKT_VIDEO   = 8'h00;
  localparam logic [7:0]  PKT_AUDIO   = 8'h01;
  localparam int unsigned IFG_DEFAULT = 12;
  localparam int unsigned TMR_W       = 16;

  // IP identification advances by one per completed frame and wraps naturally.
  function automatic logic [15:0] iden_next(input logic [15:0] iden);
    return iden + 16'd1;
  endfunction

endpackage

// File: rtl/gmii_sched_timer.sv
// Loadable up-counter that stops at, and flags, a programmable terminal value.
// Used for the frame watchdog and the inter-frame gap.
module gmii_sched_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic [W-1:0] term_val_i,
  output logic         term_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign term_o = (cnt_q == term_val_i);

  // Next count: load wins, otherwise count up until the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && !term_o) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gmii_tx_sched.sv
// gmii_tx_sched: arbitrates the GMII tx path between video and audio, with IFG and watchdog.
// Build macro GMII_TX_SCHED_STATS_EN adds per-source frame and drop counters.
module gmii_tx_sched
  import gmii_tx_pkg::*;
#(
  parameter int unsigned VIDEO_BURST      = 4,
  parameter int unsigned AUDIO_TIMEOUT    = 1024,
  parameter int unsigned IFG_CYCLES       = IFG_DEFAULT,
  parameter int unsigned MAX_FRAME_CYCLES = 4095
) (
  input  logic        tx_clk,
  input  logic        sys_rst_n,
  input  logic        vid_req,
  input  logic        aud_req,
  input  logic        tx_done,
  input  logic        err_clr,
  output logic        tx_start,
  output logic [7:0]  tx_sel,
  output logic [15:0] tx_iden,
  output logic        vid_gnt,
  output logic        aud_gnt,
  output logic        busy,
  output logic        err_timeout
`ifdef GMII_TX_SCHED_STATS_EN
  ,
  output logic [15:0] vid_frames,
  output logic [15:0] aud_frames,
  output logic [15:0] drop_frames
`endif
);

  localparam int unsigned       SW       = $clog2(VIDEO_BURST + 1);
  localparam int unsigned       WW       = $clog2(AUDIO_TIMEOUT + 1);
  localparam logic [SW-1:0]     BURST_L  = SW'(VIDEO_BURST);
  localparam logic [WW-1:0]     WAIT_L   = WW'(AUDIO_TIMEOUT);
  localparam logic [TMR_W-1:0]  WD_TERM  = TMR_W'(MAX_FRAME_CYCLES);
  localparam logic [TMR_W-1:0]  GAP_TERM = TMR_W'(IFG_CYCLES - 1);

  sched_state_e  state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [7:0]    sel_q, sel_d;
  logic [15:0]   iden_q, iden_d;
  logic          start_q, start_d, busy_q, busy_d, err_q, err_d;
  logic          vgnt_q, vgnt_d, agnt_q, agnt_d;
  logic          grant_vid_s, grant_aud_s, done_s, tmo_s, wd_term_s, gap_term_s;

  // Watchdog starts from zero in START; the gap timer starts from zero on entering GAP.
  gmii_sched_timer #(.W(TMR_W)) u_wdog (
    .clk_i      (tx_clk),
    .rst_n_i    (sys_rst_n),
    .load_i     (grant_vid_s | grant_aud_s),
    .load_val_i ({TMR_W{1'b0}}),
    .en_i       ((state_q == START) || (state_q == FRAME)),
    .term_val_i (WD_TERM),
    .term_o     (wd_term_s)
  );

  gmii_sched_timer #(.W(TMR_W)) u_gap (
    .clk_i      (tx_clk),
    .rst_n_i    (sys_rst_n),
    .load_i     (done_s | tmo_s),
    .load_val_i ({TMR_W{1'b0}}),
    .en_i       (state_q == GAP),
    .term_val_i (GAP_TERM),
    .term_o     (gap_term_s)
  );

  // Arbitration and state sequencing.
  always_comb begin
    state_d     = state_q;
    grant_vid_s = 1'b0;
    grant_aud_s = 1'b0;
    done_s      = 1'b0;
    tmo_s       = 1'b0;
    case (state_q)
      IDLE: begin
        if (vid_req && aud_req) begin
          if ((wait_q == WAIT_L) || (streak_q >= BURST_L)) begin
            grant_aud_s = 1'b1;
          end else begin
            grant_vid_s = 1'b1;
          end
        end else if (aud_req) begin
          grant_aud_s = 1'b1;
        end else if (vid_req) begin
          grant_vid_s = 1'b1;
        end else begin
          grant_vid_s = 1'b0;
        end
        if (grant_vid_s || grant_aud_s) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: state_d = FRAME;
      FRAME: begin
        // A done coincident with expiry counts as a completed frame.
        if (tx_done) begin
          done_s  = 1'b1;
          state_d = GAP;
        end else if (wd_term_s) begin
          tmo_s   = 1'b1;
          state_d = GAP;
        end else begin
          state_d = FRAME;
        end
      end
      GAP: begin
        if (gap_term_s) begin
          state_d = IDLE;
        end else begin
          state_d = GAP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values for the registered outputs and fairness counters.
  always_comb begin
    start_d  = (state_d == START);
    busy_d   = (state_d != IDLE);
    sel_d    = sel_q;
    vgnt_d   = vgnt_q;
    agnt_d   = agnt_q;
    streak_d = streak_q;
    if (grant_aud_s) begin
      sel_d    = PKT_AUDIO;
      agnt_d   = 1'b1;
      streak_d = {SW{1'b0}};
    end else if (grant_vid_s) begin
      sel_d  = PKT_VIDEO;
      vgnt_d = 1'b1;
      if (streak_q != BURST_L) begin
        streak_d = streak_q + SW'(1);
      end else begin
        streak_d = streak_q;
      end
    end else if (done_s || tmo_s) begin
      vgnt_d = 1'b0;
      agnt_d = 1'b0;
    end else begin
      sel_d = sel_q;
    end
    iden_d = done_s ? iden_next(iden_q) : iden_q;
    if (tmo_s) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
    // Audio ages only while it is waiting, not while it owns the path.
    if (grant_aud_s || !aud_req) begin
      wait_d = {WW{1'b0}};
    end else if (!agnt_q && (wait_q != WAIT_L)) begin
      wait_d = wait_q + WW'(1);
    end else begin
      wait_d = wait_q;
    end
  end

  // State and output registers.
  always_ff @(posedge tx_clk) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      streak_q <= {SW{1'b0}};
      wait_q   <= {WW{1'b0}};
      sel_q    <= 8'h00;
      iden_q   <= 16'h0000;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      vgnt_q   <= 1'b0;
      agnt_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      wait_q   <= wait_d;
      sel_q    <= sel_d;
      iden_q   <= iden_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      vgnt_q   <= vgnt_d;
      agnt_q   <= agnt_d;
    end
  end

  assign tx_start    = start_q;
  assign tx_sel      = sel_q;
  assign tx_iden     = iden_q;
  assign vid_gnt     = vgnt_q;
  assign aud_gnt     = agnt_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

`ifdef GMII_TX_SCHED_STATS_EN
  logic [15:0] vid_cnt_q, aud_cnt_q, drop_cnt_q;

  // Wrapping frame statistics.
  always_ff @(posedge tx_clk) begin
    if (!sys_rst_n) begin
      vid_cnt_q  <= 16'h0000;
      aud_cnt_q  <= 16'h0000;
      drop_cnt_q <= 16'h0000;
    end else begin
      if (done_s && vgnt_q) vid_cnt_q <= vid_cnt_q + 16'd1;
      if (done_s && agnt_q) aud_cnt_q <= aud_cnt_q + 16'd1;
      if (tmo_s) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign vid_frames  = vid_cnt_q;
  assign aud_frames  = aud_cnt_q;
  assign drop_frames = drop_cnt_q;
`endif

endmodule

// File: tb/tb_gmii_tx_sched.sv
// Scoreboard bench for gmii_tx_sched: a cycle-numbered reference model predicts every
// grant and output level; a monitor compares the DUT against it on the falling edge.
module tb_gmii_tx_sched;

  localparam int BURST = 4;
  localparam int TO    = 64;
  localparam int IFG   = 12;
  localparam int MAXF  = 1500;

  logic        tx_clk, sys_rst_n, vid_req, aud_req, err_clr, done_auto, spur;
  wire         tx_done = done_auto | spur;
  logic        tx_start, vid_gnt, aud_gnt, busy, err_timeout;
  logic [7:0]  tx_sel;
  logic [15:0] tx_iden;

  gmii_tx_sched #(
    .VIDEO_BURST(BURST), .AUDIO_TIMEOUT(TO), .IFG_CYCLES(IFG), .MAX_FRAME_CYCLES(MAXF)
  ) dut (
    .tx_clk(tx_clk), .sys_rst_n(sys_rst_n), .vid_req(vid_req), .aud_req(aud_req),
    .tx_done(tx_done), .err_clr(err_clr), .tx_start(tx_start), .tx_sel(tx_sel),
    .tx_iden(tx_iden), .vid_gnt(vid_gnt), .aud_gnt(aud_gnt), .busy(busy),
    .err_timeout(err_timeout)
  );

  typedef struct {int per; logic [7:0] sel; logic [15:0] iden;} rec_t;
  rec_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 0;

  // Reference model state (cycle numbers, counts, expected visible outputs)
  bit   m_in_frame = 0, m_src_aud = 0;
  int   m_S = 0, m_free = 0, m_streak = 0, m_wait = 0, m_grants = 0;
  logic [15:0] m_iden = 16'h0000;
  bit   exp_start = 0, exp_vg = 0, exp_ag = 0, exp_busy = 0, exp_err = 0;
  logic [7:0] exp_sel = 8'h00;

  // Frame length control for the tx_done generator
  int len_mode = 0, len_lo = 1, len_hi = 40, fixed_len = 100;

  initial begin
    tx_clk = 1'b0;
    forever #4 tx_clk = ~tx_clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: applies the scheduling rules to the inputs seen at each rising edge.
  initial begin
    bit gv, ga, ended, tmo, own;
    forever begin
      @(posedge tx_clk);
      exp_start = 1'b0;
      if (!sys_rst_n) begin
        m_in_frame = 0; m_free = cyc + 1; m_streak = 0; m_wait = 0; m_iden = 16'h0000;
        exp_err = 0; exp_sel = 8'h00; exp_vg = 0; exp_ag = 0; exp_busy = 0;
        exp_q.delete();
      end else begin
        gv = 0; ga = 0; ended = 0; tmo = 0;
        own = m_in_frame && m_src_aud;
        if (m_in_frame) begin
          if (cyc > m_S && tx_done) ended = 1;
          else if (cyc == m_S + MAXF) begin ended = 1; tmo = 1; end
        end else if (cyc >= m_free) begin
          if (vid_req && aud_req) begin
            if (m_wait == TO || m_streak >= BURST) ga = 1; else gv = 1;
          end else begin
            ga = aud_req; gv = vid_req;
          end
        end
        if (tmo) exp_err = 1; else if (err_clr) exp_err = 0;
        if (ga || !aud_req) m_wait = 0;
        else if (!own && m_wait < TO) m_wait++;
        if (gv && m_streak < BURST) m_streak++;
        if (ga) m_streak = 0;
        if (ended) begin
          m_in_frame = 0; m_free = cyc + IFG + 1; exp_vg = 0; exp_ag = 0;
          if (!tmo) m_iden = m_iden + 16'd1;
        end
        if (gv || ga) begin
          m_in_frame = 1; m_S = cyc + 1; m_src_aud = ga; m_grants++;
          exp_sel = ga ? 8'h01 : 8'h00; exp_vg = gv; exp_ag = ga; exp_start = 1;
          exp_q.push_back('{per: cyc + 1, sel: exp_sel, iden: m_iden});
        end
        exp_busy = m_in_frame || (cyc + 1 < m_free);
      end
      cyc++;
    end
  end

  // tx_done generator: one pulse per frame, a chosen number of cycles after tx_start.
  initial begin
    int plan_id, plan_at;
    plan_id = -1; plan_at = -1; done_auto = 1'b0;
    forever begin
      @(negedge tx_clk);
      if (m_in_frame && plan_id != m_grants) begin
        plan_id = m_grants;
        case (len_mode)
          0: plan_at = m_S + $urandom_range(len_hi, len_lo);
          1: plan_at = m_S + fixed_len;
          default: plan_at = -1;
        endcase
      end
      done_auto = m_in_frame && (cyc == plan_at);
    end
  end

  // Monitor: compares DUT outputs with the model every cycle and pops a record per tx_start.
  initial begin
    rec_t r;
    forever begin
      @(negedge tx_clk);
      if (mon_en) begin
        chk("tx_start", tx_start, exp_start);
        chk("tx_sel", tx_sel, exp_sel);
        chk("tx_iden", tx_iden, m_iden);
        chk("vid_gnt", vid_gnt, exp_vg);
        chk("aud_gnt", aud_gnt, exp_ag);
        chk("busy", busy, exp_busy);
        chk("err_timeout", err_timeout, exp_err);
        chk("gnt_exclusive", vid_gnt & aud_gnt, 1'b0);
        if (tx_start === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("start_expected", 1'b1, 1'b0);
          end else begin
            r = exp_q.pop_front();
            chk("start_cycle", cyc, r.per);
            chk("start_sel", tx_sel, r.sel);
            chk("start_iden", tx_iden, r.iden);
          end
        end
      end
    end
  end

  task automatic wait_grants(input int n);
    int target;
    target = m_grants + n;
    for (int i = 0; i < 20000 && m_grants < target; i++) @(negedge tx_clk);
    if (m_grants < target) chk("grant_budget", m_grants, target);
  endtask

  task automatic wait_frame_end();
    for (int i = 0; i < MAXF + 100 && m_in_frame; i++) @(negedge tx_clk);
    if (m_in_frame) chk("frame_end_budget", 1'b1, 1'b0);
  endtask

  // Stimulus sequence
  initial begin
    sys_rst_n = 1'b0; vid_req = 1'b0; aud_req = 1'b0; err_clr = 1'b0; spur = 1'b0;
    repeat (3) @(negedge tx_clk);
    sys_rst_n = 1'b1; mon_en = 1;
    // Video only, long then short frames
    len_mode = 1; fixed_len = 1400; vid_req = 1'b1;
    wait_grants(3);
    len_mode = 0; len_lo = 1; len_hi = 40;
    wait_grants(6);
    // Both requesting with short frames: burst limit drives the pattern
    len_hi = 3; aud_req = 1'b1;
    wait_grants(15);
    // Audio ages during a long video frame and preempts before the burst limit
    vid_req = 1'b0; wait_grants(2);
    aud_req = 1'b0; vid_req = 1'b1; len_mode = 1; fixed_len = 200;
    wait_grants(1);
    repeat (20) @(negedge tx_clk);
    aud_req = 1'b1; len_mode = 0; len_hi = 20;
    wait_grants(2);
    // Watchdog expiry, request dropped mid-frame, then clear
    aud_req = 1'b0; len_mode = 2;
    wait_grants(1);
    vid_req = 1'b0;
    wait_frame_end();
    repeat (5) @(negedge tx_clk);
    err_clr = 1'b1; @(negedge tx_clk); err_clr = 1'b0;
    // Second expiry with err_clr held across it
    vid_req = 1'b1; wait_grants(1); vid_req = 1'b0; err_clr = 1'b1;
    wait_frame_end();
    repeat (3) @(negedge tx_clk);
    err_clr = 1'b0;
    // Done coincident with watchdog expiry
    len_mode = 1; fixed_len = MAXF; vid_req = 1'b1;
    wait_grants(1); vid_req = 1'b0;
    wait_frame_end();
    // Random requests, lengths and clears
    len_mode = 0; len_lo = 1; len_hi = 60;
    for (int i = 0; i < 2500; i++) begin
      @(negedge tx_clk);
      if ($urandom_range(15, 0) == 0) vid_req = $urandom_range(1, 0);
      if ($urandom_range(15, 0) == 0) aud_req = $urandom_range(1, 0);
      err_clr = ($urandom_range(31, 0) == 0);
    end
    err_clr = 1'b0; aud_req = 1'b0;
    // Reset in the middle of a frame, then a stray tx_done
    len_mode = 1; fixed_len = 100; vid_req = 1'b1;
    wait_frame_end();
    wait_grants(1);
    repeat (20) @(negedge tx_clk);
    sys_rst_n = 1'b0; vid_req = 1'b0;
    @(negedge tx_clk);
    sys_rst_n = 1'b1; spur = 1'b1;
    @(negedge tx_clk);
    spur = 1'b0;
    repeat (30) @(negedge tx_clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #(60000 * 8);
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/gmii_tx_sched.md
Name: gmii_tx_sched

Overview:
Frame-level scheduler for the GMII transmit engine. It shares the single tx path between the video FIFO requester and the audio/AUX FIFO requester. It decides which source sends the next frame, issues a start strobe with a packet-type code and IP identification value, then waits for frame completion. After each frame it enforces the inter-frame gap and guards against a hung engine with a watchdog.

Parameters:
VIDEO_BURST, 4, max consecutive video frames granted while audio is pending
AUDIO_TIMEOUT, 1024, tx_clk cycles audio may wait before it preempts video priority
IFG_CYCLES, 12, idle cycles enforced after tx_done before the next arbitration
MAX_FRAME_CYCLES, 4095, watchdog limit from tx_start to tx_done

Ports:
tx_clk  in  1  GMII transmit clock (125 MHz); the single clock
sys_rst_n  in  1  synchronous, active-low reset
vid_req  in  1  video frame ready (FIFO non-empty and send enabled); level
aud_req  in  1  audio frame ready (AUX FIFO non-empty and ADE pending); level
tx_done  in  1  one-cycle pulse from the tx engine on the last FCS byte
err_clr  in  1  clears err_timeout
tx_start  out  1  one-cycle start strobe to the tx engine
tx_sel  out  8  packet type: 8'h00 video, 8'h01 audio
tx_iden  out  16  IP identification for the current frame
vid_gnt  out  1  video owns the tx path
aud_gnt  out  1  audio owns the tx path
busy  out  1  high in every state except IDLE
err_timeout  out  1  sticky watchdog error

Behaviour:
- Reset (sys_rst_n=0 at a clock edge) takes effect regardless of current state:
  - All outputs go to 0; tx_sel=8'h00; tx_iden=16'h0000.
  - Internal state: video_streak=0, audio_wait=0, state=IDLE.
- States: IDLE, START, FRAME, GAP.
- IDLE, arbitration at every clock:
  - Both requests high: grant audio if audio_wait==AUDIO_TIMEOUT or video_streak>=VIDEO_BURST; otherwise grant video.
  - Only one request high: grant that source.
  - No request: stay in IDLE.
  - On a grant: go to START, load tx_sel, assert the matching gnt.
- START, one cycle:
  - tx_start=1.
  - tx_iden holds the value for this frame.
  - Go to FRAME; watchdog reloads to 0.
- FRAME:
  - gnt and tx_sel stay stable.
  - The watchdog increments each cycle.
  - tx_done: drop gnt, tx_iden <= tx_iden+1 (wraps 16'hFFFF to 0), go to GAP.
  - Watchdog == MAX_FRAME_CYCLES with no tx_done: set err_timeout, drop gnt, go to GAP; tx_iden is not incremented.
  - tx_done in the same cycle as watchdog expiry: treated as done; no error.
- GAP:
  - Counts IFG_CYCLES cycles, then returns to IDLE.
  - Minimum spacing from tx_done to the next tx_start is IFG_CYCLES+2 cycles.
- tx_done outside FRAME is ignored.
- vid_gnt and aud_gnt are never high together.
- Fairness counters:
  - video_streak: +1 on each video grant, saturating at VIDEO_BURST; cleared on each audio grant.
  - audio_wait: +1 each cycle aud_req=1 and audio is not granted, saturating at AUDIO_TIMEOUT; cleared on an audio grant or when aud_req=0.
- A request dropping after grant does not abort the frame.
- err_timeout stays set until err_clr=1. If err_clr and a new timeout occur in the same cycle, the set wins.

Optional Feature:
GMII_TX_SCHED_STATS_EN:
- Defined: adds outputs vid_frames[15:0], aud_frames[15:0], drop_frames[15:0].
  - vid_frames / aud_frames increment on each successful tx_done for that source.
  - drop_frames increments on each watchdog timeout.
  - All three are wrapping counters, reset to 0.
- Undefined: these ports are absent and no counter logic is built.

Decomposition:
- Shared package gmii_tx_pkg:
  - state encoding (IDLE/START/FRAME/GAP);
  - packet-type constants PKT_VIDEO=8'h00 and PKT_AUDIO=8'h01, which the tx engine uses too;
  - default IFG constant.
- One sub-module, gmii_sched_timer: a loadable counter with terminal flag. It is instanced for the watchdog and the IFG gap; it is not instanced for audio_wait.

Test Plan:
- Video-only stream: vid_req=1 steady, tx_done 1400 cycles after each start.
  - Expect tx_sel=8'h00 every frame.
  - tx_iden sequence 0,1,2,...
  - tx_done to next tx_start = IFG_CYCLES+2 = 14 cycles.
- Contention via burst limit: vid_req=1 and aud_req=1 steady, VIDEO_BURST=4.
  - Expect a repeating pattern of 4 video grants, then 1 audio grant.
- Contention via timeout: aud_req raised during a long video frame with AUDIO_TIMEOUT=16.
  - Expect the next grant after GAP to be audio, even though video_streak<VIDEO_BURST.
- Watchdog: grant video and withhold tx_done.
  - At cycle MAX_FRAME_CYCLES, err_timeout=1 and vid_gnt=0.
  - tx_iden unchanged.
  - err_clr then clears the flag.
- tx_done coincident with watchdog expiry: no error, tx_iden increments.
- Reset in FRAME: sys_rst_n=0 for 1 cycle.
  - All outputs return to reset values and state=IDLE.
  - A spurious tx_done after reset is ignored.
